// File: rtl/calculator_pkg.sv
// Shared types and constants for the calculator arbiter slice.
// Imported by the arbiter and the top-level issue/response logic.
package calculator_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } func_t;

  localparam int DEFAULT_LATENCY_BLOCK = 3;
  localparam int MAX_REQ               = 8;
  localparam int ID_W                  = 3;

  // Saturation values the calculator produces for a divide by zero.
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            dz;
  } tag_t;

  function automatic logic isDivByZero(input logic [1:0] func, input logic [7:0] b);
    return (func_t'(func) == DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from ptr,
// ptr advances past the winner only on a grant.
module rr_arbiter
  import calculator_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hold,
  input  logic [NUM_REQ-1:0] i_reqValid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grantValid,
  output logic [ID_W-1:0]    o_grantId
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;
  logic [ID_W-1:0]    w_id;

  // Two passes: indices at or above ptr first, then the wrapped-around ones.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_id    = '0;
    if (i_rst_n && !i_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (i >= int'(r_ptr)) && i_reqValid[i]) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_id       = ID_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (i < int'(r_ptr)) && i_reqValid[i]) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_id       = ID_W'(i);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      if (int'(w_id) == NUM_REQ - 1) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_id + 1'b1;
      end
    end
  end

  assign o_grant      = w_grant;
  assign o_grantValid = w_found;
  assign o_grantId    = w_id;

endmodule

// File: rtl/calculator_arbiter.sv
// Shares one pipelined calculator among NUM_REQ requesters; a tag pipeline
// matched to the calculator latency routes each result back to its requester.
module calculator_arbiter
  import calculator_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int LATENCY_BLOCK = DEFAULT_LATENCY_BLOCK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*2-1:0] req_func,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [1:0]           func_in,
  output logic [7:0]           A_in,
  output logic [7:0]           B_in,
  input  logic [15:0]          out,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_dz,
  output logic                 idle
);

  logic [NUM_REQ-1:0] w_grant;
  logic               w_grantValid;
  logic [ID_W-1:0]    w_grantId;
  logic [1:0]         w_selFunc;
  logic [7:0]         w_selA;
  logic [7:0]         w_selB;
  tag_t               w_stage0;
  tag_t               w_lastTag;
  logic               w_anyTag;

  logic [1:0]         r_funcIn;
  logic [7:0]         r_aIn;
  logic [7:0]         r_bIn;
  tag_t               r_tags [LATENCY_BLOCK+1];
  logic [NUM_REQ-1:0] r_rspValid;
  logic [15:0]        r_rspData;
  logic               r_rspDz;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arbiter (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hold      (hold),
    .i_reqValid  (req_valid),
    .o_grant     (w_grant),
    .o_grantValid(w_grantValid),
    .o_grantId   (w_grantId)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_selFunc = '0;
    w_selA    = '0;
    w_selB    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_selFunc = req_func[i*2 +: 2];
        w_selA    = req_a[i*8 +: 8];
        w_selB    = req_b[i*8 +: 8];
      end
    end
  end

  // Calculator operands only move on a handshake so an idle calculator sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funcIn <= '0;
      r_aIn    <= '0;
      r_bIn    <= '0;
    end else if (w_grantValid) begin
      r_funcIn <= w_selFunc;
      r_aIn    <= w_selA;
      r_bIn    <= w_selB;
    end
  end

  always_comb begin
    w_stage0       = '0;
    w_stage0.valid = w_grantValid;
    if (w_grantValid) begin
      w_stage0.id = w_grantId;
      w_stage0.dz = isDivByZero(w_selFunc, w_selB);
    end
  end

  // Tags never stall: the calculator accepts one op per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LATENCY_BLOCK; k++) begin
        r_tags[k] <= '0;
      end
    end else begin
      r_tags[0] <= w_stage0;
      for (int k = 1; k <= LATENCY_BLOCK; k++) begin
        r_tags[k] <= r_tags[k-1];
      end
    end
  end

  assign w_lastTag = r_tags[LATENCY_BLOCK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_rspDz    <= 1'b0;
    end else if (w_lastTag.valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rspValid[i] <= (w_lastTag.id == ID_W'(i));
      end
      r_rspData <= out;
      r_rspDz   <= w_lastTag.dz;
    end else begin
      r_rspValid <= '0;
    end
  end

  always_comb begin
    w_anyTag = 1'b0;
    for (int k = 0; k <= LATENCY_BLOCK; k++) begin
      w_anyTag = w_anyTag | r_tags[k].valid;
    end
  end

  assign idle      = !w_anyTag && (r_rspValid == '0);
  assign func_in   = r_funcIn;
  assign A_in      = r_aIn;
  assign B_in      = r_bIn;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_dz    = r_rspDz;

endmodule

// File: tb/tb_calculator_arbiter.sv
// Bench for calculator_arbiter: calculator stub, requester queues, a spec-level
// model compared every cycle, and directed scenarios with literal expectations.
module tb_calculator_arbiter;
  import calculator_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 hold;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*2-1:0] req_func;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [1:0]           func_in;
  logic [7:0]           A_in;
  logic [7:0]           B_in;
  logic [15:0]          out;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_dz;
  logic                 idle;

  typedef struct {logic [1:0] f; logic [7:0] a; logic [7:0] b;} op_t;
  typedef struct {int id; logic [15:0] data; logic dz; int due;} exp_t;
  typedef struct {logic [NUM_REQ-1:0] vec; logic [15:0] data; logic dz; int cyc;} rsp_t;

  op_t  reqQ [NUM_REQ][$];
  exp_t expQ[$];
  int   grantLog[$];
  rsp_t rspLog[$];

  int assertCount = 0;
  int failCount   = 0;
  int gCyc        = 0;
  logic checkEn   = 1'b0;

  int                 mPtr      = 0;
  int                 mCyc      = 0;
  logic [NUM_REQ-1:0] mRspVec   = '0;
  logic [15:0]        mLastData = '0;
  logic               mLastDz   = 1'b0;

  logic [15:0] calcPipe [LAT];

  always #5 clk = ~clk;
  always @(posedge clk) gCyc <= gCyc + 1;

  calculator_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LATENCY_BLOCK(LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .req_valid(req_valid),
    .req_func (req_func),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .func_in  (func_in),
    .A_in     (A_in),
    .B_in     (B_in),
    .out      (out),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_dz   (rsp_dz),
    .idle     (idle)
  );

  // Reference arithmetic of the calculator, including divide-by-zero saturation.
  function automatic logic [15:0] calcRef(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int r;
    case (f)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sa * sb;
      default: begin
        if (sb == 0) r = (sa < 0) ? 32'sh8000 : 32'sh7FFF;
        else         r = sa / sb;
      end
    endcase
    return r[15:0];
  endfunction

  function automatic int modelWinner(input logic [NUM_REQ-1:0] v, input logic h, input int p);
    if (h) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int oneHotIdx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Calculator stub: samples its inputs every edge, result appears LAT edges later.
  always @(posedge clk) begin
    calcPipe[0] <= calcRef(func_in, A_in, B_in);
    for (int k = 1; k < LAT; k++) calcPipe[k] <= calcPipe[k-1];
  end
  assign out = calcPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
    op_t op;
    op.f = f; op.a = a; op.b = b;
    reqQ[idx].push_back(op);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic queuesEmpty();
    for (int i = 0; i < NUM_REQ; i++) if (reqQ[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitIdle(input int budget, input string name);
    int k = 0;
    logic done = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
      done = idle && (rsp_valid == '0) && queuesEmpty();
    end
    checkOutput({name, "_drained"}, done, 1);
  endtask

  task automatic clearLogs();
    grantLog.delete();
    rspLog.delete();
  endtask

  // Requester side: hold each op until its handshake, then present the next.
  initial begin
    logic [NUM_REQ-1:0] drvHs;
    forever begin
      @(negedge clk);
      drvHs = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drvHs[i] && reqQ[i].size() > 0) reqQ[i].delete(0);
        if (reqQ[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_func[i*2 +: 2] = reqQ[i][0].f;
          req_a[i*8 +: 8]    = reqQ[i][0].a;
          req_b[i*8 +: 8]    = reqQ[i][0].b;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Behavioural model: arbitration rule plus a queue of responses due at fixed cycles.
  initial begin
    int w;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        expQ.delete();
        mPtr = 0; mRspVec = '0; mLastData = '0; mLastDz = 1'b0;
      end else begin
        mCyc++;
        mRspVec = '0;
        if (expQ.size() > 0 && expQ[0].due == mCyc) begin
          mRspVec[expQ[0].id] = 1'b1;
          mLastData = expQ[0].data;
          mLastDz   = expQ[0].dz;
          expQ.delete(0);
        end
        w = modelWinner(req_valid, hold, mPtr);
        if (w >= 0) begin
          e.id   = w;
          e.data = calcRef(req_func[w*2 +: 2], req_a[w*8 +: 8], req_b[w*8 +: 8]);
          e.dz   = (req_func[w*2 +: 2] == 2'b11) && (req_b[w*8 +: 8] == 8'h00);
          e.due  = mCyc + LAT + 1;
          expQ.push_back(e);
          mPtr = (w + 1) % NUM_REQ;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    int w;
    logic [NUM_REQ-1:0] expReady;
    forever begin
      @(negedge clk);
      if (rst_n && checkEn) begin
        w = modelWinner(req_valid, hold, mPtr);
        expReady = '0;
        if (w >= 0) expReady[w] = 1'b1;
        checkOutput("cmp_req_ready", req_ready, expReady);
        checkOutput("cmp_rsp_valid", rsp_valid, mRspVec);
        checkOutput("cmp_rsp_data", rsp_data, mLastData);
        checkOutput("cmp_rsp_dz", rsp_dz, mLastDz);
        checkOutput("cmp_idle", idle, (expQ.size() == 0) && (mRspVec == '0));
      end
    end
  end

  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((req_valid & req_ready) != '0) grantLog.push_back(oneHotIdx(req_valid & req_ready));
        if (rsp_valid != '0) begin
          r.vec = rsp_valid; r.data = rsp_data; r.dz = rsp_dz; r.cyc = gCyc;
          rspLog.push_back(r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int hStart;
    int idleLat;
    logic idleSeen;
    int expG [6] = '{0, 1, 2, 3, 0, 1};
    logic [15:0] expD [6] = '{16'h001E, 16'hFFFC, 16'hFFEB, 16'h000E, 16'hFFFE, 16'h0090};

    rst_n = 1'b0; hold = 1'b0;
    req_valid = '0; req_func = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_idle", idle, 1);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    checkEn = 1'b1;

    $display("[TB] single op");
    waitCycle();
    clearLogs();
    applyStimulus(0, 2'b00, 8'd5, 8'd3);
    t0 = gCyc;
    waitIdle(20, "single");
    checkOutput("single_rsp_count", rspLog.size(), 1);
    if (rspLog.size() > 0) begin
      checkOutput("single_rsp_valid", rspLog[0].vec, 4'b0001);
      checkOutput("single_rsp_data", rspLog[0].data, 16'h0008);
      checkOutput("single_rsp_dz", rspLog[0].dz, 0);
      checkOutput("single_latency", rspLog[0].cyc - t0, LAT + 2);
    end

    $display("[TB] fairness");
    waitCycle();
    rst_n = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    clearLogs();
    applyStimulus(0, 2'b00, 8'd10, 8'd20);
    applyStimulus(0, 2'b00, 8'hFF, 8'hFF);
    applyStimulus(1, 2'b01, 8'd5, 8'd9);
    applyStimulus(1, 2'b10, 8'd12, 8'd12);
    applyStimulus(2, 2'b10, 8'd7, 8'hFD);
    applyStimulus(3, 2'b11, 8'd100, 8'd7);
    waitIdle(40, "fair");
    checkOutput("fair_grant_count", grantLog.size(), 6);
    checkOutput("fair_rsp_count", rspLog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < grantLog.size()) checkOutput($sformatf("fair_grant_%0d", k), grantLog[k], expG[k]);
      if (k < rspLog.size()) begin
        checkOutput($sformatf("fair_rsp_id_%0d", k), oneHotIdx(rspLog[k].vec), expG[k]);
        checkOutput($sformatf("fair_rsp_data_%0d", k), rspLog[k].data, expD[k]);
        checkOutput($sformatf("fair_rsp_gap_%0d", k), rspLog[k].cyc - rspLog[0].cyc, k);
      end
    end

    $display("[TB] divide by zero");
    waitCycle();
    clearLogs();
    applyStimulus(2, 2'b11, 8'hF6, 8'h00);
    applyStimulus(2, 2'b11, 8'h0A, 8'h00);
    waitIdle(30, "dz");
    checkOutput("dz_rsp_count", rspLog.size(), 2);
    if (rspLog.size() > 1) begin
      checkOutput("dz_neg_valid", rspLog[0].vec, 4'b0100);
      checkOutput("dz_neg_data", rspLog[0].data, SAT_NEG);
      checkOutput("dz_neg_flag", rspLog[0].dz, 1);
      checkOutput("dz_pos_data", rspLog[1].data, SAT_POS);
      checkOutput("dz_pos_flag", rspLog[1].dz, 1);
    end

    $display("[TB] hold");
    waitCycle();
    clearLogs();
    applyStimulus(0, 2'b00, 8'd1, 8'd2);
    applyStimulus(1, 2'b00, 8'd3, 8'd4);
    applyStimulus(2, 2'b00, 8'd5, 8'd6);
    repeat (3) waitCycle();
    hold = 1'b1;
    applyStimulus(3, 2'b01, 8'd9, 8'd4);
    applyStimulus(1, 2'b10, 8'd2, 8'd3);
    hStart = gCyc;
    idleSeen = 1'b0;
    idleLat = -1;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      checkOutput("hold_req_ready", req_ready, 0);
      if (!idleSeen && idle) begin
        idleSeen = 1'b1;
        idleLat = gCyc - hStart;
      end
    end
    checkOutput("hold_idle_seen", idleSeen, 1);
    checkOutput("hold_idle_within", (idleLat >= 0) && (idleLat <= LAT + 2), 1);
    checkOutput("hold_rsp_count", rspLog.size(), 3);
    waitCycle();
    hold = 1'b0;
    grantLog.delete();
    waitIdle(30, "hold_release");
    checkOutput("hold_grant_count", grantLog.size(), 2);
    if (grantLog.size() > 1) begin
      checkOutput("hold_resume_first", grantLog[0], 3);
      checkOutput("hold_resume_second", grantLog[1], 1);
    end

    $display("[TB] mid-operation reset");
    waitCycle();
    applyStimulus(1, 2'b00, 8'h11, 8'h22);
    applyStimulus(2, 2'b01, 8'h40, 8'h01);
    repeat (2) waitCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_req_ready", req_ready, 0);
    checkOutput("mrst_rsp_valid", rsp_valid, 0);
    checkOutput("mrst_rsp_data", rsp_data, 0);
    checkOutput("mrst_rsp_dz", rsp_dz, 0);
    checkOutput("mrst_func_in", func_in, 0);
    checkOutput("mrst_a_in", A_in, 0);
    checkOutput("mrst_b_in", B_in, 0);
    checkOutput("mrst_idle", idle, 1);
    applyStimulus(3, 2'b00, 8'd2, 8'd3);
    applyStimulus(1, 2'b01, 8'h10, 8'h01);
    repeat (3) waitCycle();
    clearLogs();
    rst_n = 1'b1;
    waitIdle(30, "mrst");
    checkOutput("mrst_grant_count", grantLog.size(), 2);
    checkOutput("mrst_rsp_count", rspLog.size(), 2);
    if (grantLog.size() > 1 && rspLog.size() > 1) begin
      checkOutput("mrst_first_grant", grantLog[0], 1);
      checkOutput("mrst_second_grant", grantLog[1], 3);
      checkOutput("mrst_rsp0_valid", rspLog[0].vec, 4'b0010);
      checkOutput("mrst_rsp0_data", rspLog[0].data, 16'h000F);
      checkOutput("mrst_rsp1_data", rspLog[1].data, 16'h0005);
    end

    $display("[TB] sparse traffic");
    waitCycle();
    clearLogs();
    for (int n = 0; n < 3; n++) begin
      applyStimulus(3, 2'b10, 8'h80, 8'h80);
      repeat (5) waitCycle();
    end
    waitIdle(20, "sparse");
    checkOutput("sparse_rsp_count", rspLog.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < rspLog.size()) begin
        checkOutput($sformatf("sparse_valid_%0d", k), rspLog[k].vec, 4'b1000);
        checkOutput($sformatf("sparse_data_%0d", k), rspLog[k].data, 16'h4000);
      end
    end
    waitCycle();
    applyStimulus(0, 2'b00, 8'd1, 8'd1);
    applyStimulus(2, 2'b00, 8'd2, 8'd2);
    waitIdle(20, "sparse_probe");
    checkOutput("sparse_grant_count", grantLog.size(), 5);
    if (grantLog.size() > 4) begin
      checkOutput("sparse_wrap_first", grantLog[3], 0);
      checkOutput("sparse_wrap_second", grantLog[4], 2);
    end

    repeat (2) waitCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
